// File: rtl/snn_output_accumulator.sv
// Output-layer membrane-potential integrator: accumulates saturating signed weight
// rows over NUM_STEPS timesteps, then runs the start/done handshake with argmax.
module snn_output_accumulator #(
  parameter int VEC_LEN      = 3,
  parameter int DATA_W       = 48,
  parameter int WEIGHT_W     = 16,
  parameter int NUM_STEPS    = 8,
  parameter int DONE_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clk_enable,
  input  logic                          i_frame_start,
  input  logic                          i_spike_valid,
  input  logic [VEC_LEN*WEIGHT_W-1:0]   i_spike_weights_flat,
  input  logic                          i_step_end,
  output logic [VEC_LEN*DATA_W-1:0]     o_potentials_flat,
  output logic                          o_argmax_start,
  input  logic                          i_argmax_done,
  input  logic [$clog2(VEC_LEN)-1:0]    i_predicted_class,
  output logic                          o_result_valid,
  output logic [$clog2(VEC_LEN)-1:0]    o_result_class,
  output logic                          o_error,
  output logic                          o_busy
);

  localparam int STEP_W = $clog2(NUM_STEPS + 1);
  localparam int WAIT_W = $clog2(DONE_TIMEOUT + 1);
  localparam logic [DATA_W-1:0] P_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] P_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    HANDOFF,
    WAIT_DONE,
    RESULT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0]   r_pot [VEC_LEN];
  logic [STEP_W-1:0]   r_step;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_error;
  logic [$clog2(VEC_LEN)-1:0] r_class;

  logic [WEIGHT_W-1:0] w_wt  [VEC_LEN];
  logic [DATA_W:0]     w_sum [VEC_LEN];
  logic [DATA_W-1:0]   w_sat [VEC_LEN];

  logic w_clear, w_accum, w_step_inc, w_step_clr;
  logic w_wait_clr, w_wait_inc, w_latch, w_err_nxt;

  // One extra bit of headroom; a disagreement between the top two sum bits is overflow.
  always_comb begin
    for (int unsigned k = 0; k < VEC_LEN; k++) begin
      w_wt[k]  = i_spike_weights_flat[k*WEIGHT_W +: WEIGHT_W];
      w_sum[k] = {r_pot[k][DATA_W-1], r_pot[k]}
               + {{(DATA_W+1-WEIGHT_W){w_wt[k][WEIGHT_W-1]}}, w_wt[k]};
      if (w_sum[k][DATA_W] != w_sum[k][DATA_W-1]) begin
        w_sat[k] = w_sum[k][DATA_W] ? P_MIN : P_MAX;
      end else begin
        w_sat[k] = w_sum[k][DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (i_clk_enable) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_accum     = 1'b0;
    w_step_inc  = 1'b0;
    w_step_clr  = 1'b0;
    w_wait_clr  = 1'b0;
    w_wait_inc  = 1'b0;
    w_latch     = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_frame_start) begin
          w_clear     = 1'b1;
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (i_frame_start) begin
          w_clear = 1'b1;
        end else begin
          w_accum = i_spike_valid;
          if (i_step_end) begin
            if (r_step == STEP_W'(NUM_STEPS - 1)) begin
              w_step_clr  = 1'b1;
              w_state_nxt = HANDOFF;
            end else begin
              w_step_inc = 1'b1;
            end
          end
        end
      end
      HANDOFF: begin
        w_wait_clr  = 1'b1;
        w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_argmax_done) begin
          w_latch     = 1'b1;
          w_state_nxt = RESULT;
        end else if (r_wait == WAIT_W'(DONE_TIMEOUT - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      RESULT: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < VEC_LEN; k++) begin
        r_pot[k] <= '0;
      end
      r_step  <= '0;
      r_wait  <= '0;
      r_error <= 1'b0;
      r_class <= '0;
    end else if (i_clk_enable) begin
      for (int unsigned k = 0; k < VEC_LEN; k++) begin
        if (w_clear) begin
          r_pot[k] <= '0;
        end else if (w_accum) begin
          r_pot[k] <= w_sat[k];
        end
      end
      if (w_clear || w_step_clr) begin
        r_step <= '0;
      end else if (w_step_inc) begin
        r_step <= r_step + 1'b1;
      end
      if (w_wait_clr) begin
        r_wait <= '0;
      end else if (w_wait_inc) begin
        r_wait <= r_wait + 1'b1;
      end
      r_error <= w_err_nxt;
      if (w_latch) begin
        r_class <= i_predicted_class;
      end
    end
  end

  always_comb begin
    o_potentials_flat = '0;
    for (int unsigned k = 0; k < VEC_LEN; k++) begin
      o_potentials_flat[k*DATA_W +: DATA_W] = r_pot[k];
    end
  end

  assign o_argmax_start = (r_state == HANDOFF);
  assign o_result_valid = (r_state == RESULT);
  assign o_result_class = r_class;
  assign o_error        = r_error;
  assign o_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_snn_output_accumulator.sv
// Bench for snn_output_accumulator: directed scenarios plus random traffic, all
// checked every cycle against an arithmetic model of the inference sequence.
module tb_snn_output_accumulator;

  localparam int VL = 3;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int NS = 2;
  localparam int TO = 15;
  localparam int CW = $clog2(VL);

  logic clk = 1'b0;
  logic rst, en, fs, sv, se, done;
  logic [CW-1:0] pc;
  logic signed [WW-1:0] wt [VL];
  logic [VL*WW-1:0] flat;
  logic [VL*DW-1:0] pot_flat;
  logic st, rv, er, bz;
  logic [CW-1:0] rc;

  assign flat = {wt[2], wt[1], wt[0]};

  always #5 clk = ~clk;

  snn_output_accumulator #(
    .VEC_LEN(VL), .DATA_W(DW), .WEIGHT_W(WW), .NUM_STEPS(NS), .DONE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .i_clk_enable(en), .i_frame_start(fs),
    .i_spike_valid(sv), .i_spike_weights_flat(flat), .i_step_end(se),
    .o_potentials_flat(pot_flat), .o_argmax_start(st),
    .i_argmax_done(done), .i_predicted_class(pc),
    .o_result_valid(rv), .o_result_class(rc), .o_error(er), .o_busy(bz)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic longint dut_pot(input int k);
    logic signed [DW-1:0] v;
    v = pot_flat[k*DW +: DW];
    return longint'(v);
  endfunction

  // Model: phase 0 idle, 1 collecting, 2 start pulse, 3 waiting, 4 result pulse.
  int     ph = 0;
  longint m_pot [VL];
  int     m_steps = 0;
  int     m_waited = 0;
  longint m_cls = 0;
  logic   m_err = 1'b0;
  logic   m_live = 1'b0;

  function automatic longint clamp(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_step();
    if (rst) begin
      ph = 0; m_steps = 0; m_waited = 0; m_cls = 0; m_err = 1'b0;
      foreach (m_pot[k]) m_pot[k] = 0;
    end else if (en) begin
      m_err = 1'b0;
      case (ph)
        0: if (fs) begin
             foreach (m_pot[k]) m_pot[k] = 0;
             m_steps = 0; ph = 1;
           end
        1: if (fs) begin
             foreach (m_pot[k]) m_pot[k] = 0;
             m_steps = 0;
           end else begin
             if (sv) foreach (m_pot[k]) m_pot[k] = clamp(m_pot[k] + longint'(wt[k]));
             if (se) begin
               m_steps++;
               if (m_steps == NS) begin m_steps = 0; ph = 2; end
             end
           end
        2: begin ph = 3; m_waited = 0; end
        3: if (done) begin
             m_cls = longint'(pc); ph = 4;
           end else begin
             m_waited++;
             if (m_waited == TO) begin m_err = 1'b1; ph = 0; end
           end
        default: ph = 0;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("start", longint'(st), longint'(ph == 2));
      chk("result_valid", longint'(rv), longint'(ph == 4));
      chk("busy", longint'(bz), longint'(ph != 0));
      chk("error", longint'(er), longint'(m_err));
      chk("result_class", longint'(rc), m_cls);
      for (int k = 0; k < VL; k++) chk($sformatf("pot%0d", k), dut_pot(k), m_pot[k]);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    m_live = 1'b1;
    #1;
  endtask

  task automatic set_w(input int a, input int b, input int c);
    wt[0] = WW'(a); wt[1] = WW'(b); wt[2] = WW'(c);
  endtask

  task automatic spike(input int a, input int b, input int c, input logic with_end);
    set_w(a, b, c); sv = 1'b1; se = with_end;
    tick();
    sv = 1'b0; se = 1'b0;
  endtask

  task automatic step_end();
    se = 1'b1; tick(); se = 1'b0;
  endtask

  task automatic frame();
    fs = 1'b1; tick(); fs = 1'b0;
  endtask

  task automatic chk_pots(input string nm, input int a, input int b, input int c);
    chk({nm, "_p0"}, dut_pot(0), a);
    chk({nm, "_p1"}, dut_pot(1), b);
    chk({nm, "_p2"}, dut_pot(2), c);
  endtask

  initial begin
    int err_at, starts, v;
    rst = 1'b1; en = 1'b1; fs = 1'b0; sv = 1'b0; se = 1'b0; done = 1'b0; pc = '0;
    set_w(0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    chk("reset_busy", longint'(bz), 0);
    chk("reset_class", longint'(rc), 0);
    chk_pots("reset", 0, 0, 0);

    // Basic run
    frame();
    spike(5, -3, 10, 1'b0);
    step_end();
    spike(1, 20, -2, 1'b0);
    step_end();
    chk_pots("basic", 6, 17, 8);
    chk("model_pot1", m_pot[1], 17);
    chk("basic_start_hi", longint'(st), 1);
    tick();
    chk("basic_start_lo", longint'(st), 0);
    tick();
    done = 1'b1; pc = 2'd1;
    tick();
    done = 1'b0;
    chk("basic_valid", longint'(rv), 1);
    chk("basic_class", longint'(rc), 1);
    tick();
    chk("basic_valid_lo", longint'(rv), 0);

    // Saturation, then done withheld until timeout
    frame();
    repeat (3) spike(100, -100, 0, 1'b0);
    chk_pots("sat", 127, -128, 0);
    chk("model_sat_lo", m_pot[1], -128);
    step_end();
    step_end();
    starts = int'(st);
    err_at = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      starts += int'(st);
      if (er) begin err_at = i; break; end
    end
    chk("timeout_cycle", err_at, 16);
    chk("start_count", starts, 1);
    chk("timeout_idle", longint'(bz), 0);
    chk("timeout_class_kept", longint'(rc), 1);
    tick();
    chk("error_pulse_lo", longint'(er), 0);

    // Spike coincident with final step_end
    frame();
    spike(1, 1, 1, 1'b1);
    spike(2, 2, 2, 1'b1);
    chk_pots("simul", 3, 3, 3);
    chk("simul_start", longint'(st), 1);
    tick();
    done = 1'b1; pc = 2'd2;
    tick();
    done = 1'b0;
    tick();
    chk("simul_class", longint'(rc), 2);

    // frame_start overrides same-cycle spike and step_end
    frame();
    spike(9, 9, 9, 1'b1);
    set_w(4, 4, 4); fs = 1'b1; sv = 1'b1; se = 1'b1;
    tick();
    fs = 1'b0; sv = 1'b0; se = 1'b0;
    chk_pots("restart", 0, 0, 0);
    step_end();
    chk("restart_no_start", longint'(st), 0);
    step_end();
    chk("restart_start", longint'(st), 1);
    tick();
    done = 1'b1; pc = 2'd0;
    tick();
    done = 1'b0;
    tick();

    // Clock enable low mid-accumulation
    frame();
    spike(3, 4, 5, 1'b0);
    en = 1'b0; set_w(7, 7, 7); sv = 1'b1;
    repeat (4) tick();
    chk_pots("gated", 3, 4, 5);
    chk("gated_busy", longint'(bz), 1);
    en = 1'b1;
    tick();
    sv = 1'b0;
    chk_pots("resumed", 10, 11, 12);
    step_end();
    step_end();
    chk("resumed_start", longint'(st), 1);
    tick();

    // Reset while waiting, with enable low
    en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1;
    chk("rst_busy", longint'(bz), 0);
    chk("rst_start", longint'(st), 0);
    chk("rst_valid", longint'(rv), 0);
    chk("rst_error", longint'(er), 0);
    chk("rst_class", longint'(rc), 0);
    chk_pots("rst", 0, 0, 0);
    done = 1'b1; pc = 2'd3;
    tick();
    done = 1'b0;
    chk("late_done_valid", longint'(rv), 0);
    chk("late_done_class", longint'(rc), 0);
    tick();
    chk("late_done_valid2", longint'(rv), 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      en   = ($urandom_range(9, 0) != 0);
      rst  = ($urandom_range(299, 0) == 0);
      fs   = ($urandom_range(39, 0) == 0);
      sv   = $urandom_range(1, 0);
      se   = ($urandom_range(5, 0) == 0);
      done = ($urandom_range(3, 0) == 0);
      pc   = CW'($urandom_range(3, 0));
      for (int k = 0; k < VL; k++) begin
        if ($urandom_range(1, 0) == 1) v = int'($urandom_range(255, 0)) - 128;
        else v = int'($urandom_range(40, 0)) - 20;
        wt[k] = WW'(v);
      end
      tick();
    end
    rst = 1'b0; en = 1'b1; fs = 1'b0; sv = 1'b0; se = 1'b0; done = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
